// File: rtl/imem_loader.sv
// Instruction-memory loader: unpacks a header-prefixed byte stream into 32-bit
// words, writes them from address 0 and holds the core until the image is in.
module imem_loader #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 1024
) (
   input  logic              clk1,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   // state   | meaning
   // HDR_HI  | waiting for word-count byte N[15:8]
   // HDR_LO  | waiting for word-count byte N[7:0]
   // DATA    | packing payload bytes, one write per 4 bytes
   // LAST    | final write on the bus, stream closed, core still held
   // DONE    | image complete, core released
   // ERR     | header count larger than the memory
   typedef enum logic [2:0] {
      S_HDR_HI, S_HDR_LO, S_DATA, S_LAST, S_DONE, S_ERR
   } state_t;

   localparam logic [16:0]     DEPTH_W = 17'(DEPTH);
   localparam logic [ADDR_W:0] ONE_W   = (ADDR_W+1)'(1);

   state_t              r_state;
   logic [15:0]         r_count;
   logic [31:0]         r_asm;
   logic [1:0]          r_byte_cnt;
   logic                r_in_ready;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [31:0]         r_mem_wdata;
   logic                r_cpu_hold;
   logic                r_done;
   logic                r_err;
   logic [ADDR_W:0]     r_words;

   logic                w_take;
   logic [31:0]         w_word;
   logic [15:0]         w_hdr_n;
   logic                w_last;

   assign w_take  = in_valid && r_in_ready;
   assign w_word  = {r_asm[23:0], in_data};
   assign w_hdr_n = {r_count[15:8], in_data};
   // words_loaded doubles as the next write address; it is the count before this write
   assign w_last  = (17'(r_words) + 17'd1) == {1'b0, r_count};

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_HDR_HI;
         r_count     <= '0;
         r_asm       <= '0;
         r_byte_cnt  <= '0;
         r_in_ready  <= 1'b1;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_hold  <= 1'b1;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_words     <= '0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            S_HDR_HI: begin
               if (w_take) begin
                  r_count[15:8] <= in_data;
                  r_state       <= S_HDR_LO;
               end
            end
            S_HDR_LO: begin
               if (w_take) begin
                  r_count[7:0] <= in_data;
                  if (w_hdr_n == 16'd0) begin
                     r_state    <= S_DONE;
                     r_done     <= 1'b1;
                     r_cpu_hold <= 1'b0;
                     r_in_ready <= 1'b0;
                  end else if ({1'b0, w_hdr_n} > DEPTH_W) begin
                     r_state    <= S_ERR;
                     r_err      <= 1'b1;
                     r_in_ready <= 1'b0;
                  end else begin
                     r_state <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (w_take) begin
                  r_asm      <= w_word;
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= r_words[ADDR_W-1:0];
                     r_mem_wdata <= w_word;
                     r_words     <= r_words + ONE_W;
                     if (w_last) begin
                        r_state    <= S_LAST;
                        r_in_ready <= 1'b0;
                     end
                  end
               end
            end
            S_LAST: begin
               r_state    <= S_DONE;
               r_done     <= 1'b1;
               r_cpu_hold <= 1'b0;
            end
            S_DONE, S_ERR: begin
               if (start) begin
                  r_state    <= S_HDR_HI;
                  r_done     <= 1'b0;
                  r_err      <= 1'b0;
                  r_cpu_hold <= 1'b1;
                  r_in_ready <= 1'b1;
                  r_byte_cnt <= '0;
                  r_words    <= '0;
               end
            end
            default: r_state <= S_HDR_HI;
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign mem_we       = r_mem_we;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign cpu_hold     = r_cpu_hold;
   assign done         = r_done;
   assign err          = r_err;
   assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header/payload streams, stalls, error and
// restart paths, reset abort and a full-depth load.
module tb_imem_loader;

   logic        clk1 = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        start;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [10:0] words_loaded;

   imem_loader #(.ADDR_W(10), .DEPTH(1024)) dut (
      .clk1(clk1), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .start(start), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .err(err),
      .words_loaded(words_loaded)
   );

   always #5 clk1 = ~clk1;

   typedef struct {
      logic [9:0]  a;
      logic [31:0] d;
      int          c;
   } wr_t;

   wr_t wq[$];
   int  cyc = 0;
   int  t_acc;
   int  n_chk = 0;
   int  n_bad = 0;

   always @(posedge clk1) cyc++;
   always @(negedge clk1) if (mem_we) wq.push_back('{a: mem_addr, d: mem_wdata, c: cyc});

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the accepting edge
   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 50) begin
         @(negedge clk1);
         n++;
      end
      if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
      @(posedge clk1);
      @(negedge clk1);
      t_acc    = cyc;
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk1);
      start = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk1);
      #1;
   endtask

   int s;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
      repeat (3) @(negedge clk1);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_words", words_loaded, 0);
      rst_n = 1'b1;
      @(negedge clk1);

      // continuous two-word load
      wq.delete();
      send_byte(8'h00); s = t_acc;
      send_byte(8'h02);
      send_word(32'h12345678);
      send_word(32'h9ABCDEF0);
      chk("t1_ready_low_after_last", in_ready, 0);
      chk("t1_done_not_yet", done, 0);
      chk("t1_hold_still", cpu_hold, 1);
      @(negedge clk1);
      chk("t1_done_time", done, 1);
      chk("t1_hold_released", cpu_hold, 0);
      chk("t1_words", words_loaded, 2);
      settle();
      chk("t1_nwr", wq.size(), 2);
      if (wq.size() == 2) begin
         chk("t1_a0", wq[0].a, 0);  chk("t1_d0", wq[0].d, 32'h12345678);
         chk("t1_c0", wq[0].c - s, 5);
         chk("t1_a1", wq[1].a, 1);  chk("t1_d1", wq[1].d, 32'h9ABCDEF0);
         chk("t1_c1", wq[1].c - s, 9);
      end

      // same stream with a 3-cycle stall inside word 0
      pulse_start();
      chk("t2_done_clr", done, 0);
      chk("t2_hold", cpu_hold, 1);
      chk("t2_words_clr", words_loaded, 0);
      chk("t2_ready", in_ready, 1);
      wq.delete();
      send_byte(8'h00); s = t_acc;
      send_byte(8'h02);
      send_byte(8'h12); send_byte(8'h34);
      repeat (3) @(negedge clk1);
      send_byte(8'h56); send_byte(8'h78);
      send_word(32'h9ABCDEF0);
      @(negedge clk1);
      chk("t2_done_time", done, 1);
      chk("t2_done_cyc", cyc - s, 13);
      settle();
      chk("t2_nwr", wq.size(), 2);
      if (wq.size() == 2) begin
         chk("t2_d0", wq[0].d, 32'h12345678); chk("t2_c0", wq[0].c - s, 8);
         chk("t2_d1", wq[1].d, 32'h9ABCDEF0); chk("t2_c1", wq[1].c - s, 12);
      end

      // oversize header, then recovery
      pulse_start();
      wq.delete();
      send_byte(8'h04); send_byte(8'h01);
      chk("t3_err", err, 1);
      chk("t3_ready", in_ready, 0);
      chk("t3_hold", cpu_hold, 1);
      chk("t3_done", done, 0);
      in_valid = 1'b1; in_data = 8'h55;
      repeat (3) @(negedge clk1);
      in_valid = 1'b0;
      chk("t3_err_stays", err, 1);
      chk("t3_no_wr", wq.size(), 0);
      pulse_start();
      chk("t3_err_clr", err, 0);
      send_byte(8'h00); send_byte(8'h01);
      send_word(32'hFC000000);
      @(negedge clk1);
      chk("t3_done", done, 1);
      chk("t3_err_low", err, 0);
      settle();
      chk("t3_nwr", wq.size(), 1);
      if (wq.size() == 1) begin
         chk("t3_a0", wq[0].a, 0); chk("t3_d0", wq[0].d, 32'hFC000000);
      end

      // zero-length image, then a one-word load
      pulse_start();
      wq.delete();
      send_byte(8'h00); send_byte(8'h00);
      chk("t4_done_n0", done, 1);
      chk("t4_hold_n0", cpu_hold, 0);
      chk("t4_ready_n0", in_ready, 0);
      settle();
      chk("t4_nwr_n0", wq.size(), 0);
      pulse_start();
      send_byte(8'h00); send_byte(8'h01);
      send_word(32'h0000002A);
      @(negedge clk1);
      chk("t4_done", done, 1);
      chk("t4_words", words_loaded, 1);
      settle();
      chk("t4_nwr", wq.size(), 1);
      if (wq.size() == 1) begin
         chk("t4_a0", wq[0].a, 0); chk("t4_d0", wq[0].d, 32'h0000002A);
      end

      // start ignored during DATA, reset aborts mid-load
      pulse_start();
      wq.delete();
      send_byte(8'h00); send_byte(8'h03);
      send_word(32'hA1A2A3A4);
      pulse_start();
      chk("t5_start_ign_done", done, 0);
      chk("t5_start_ign_ready", in_ready, 1);
      chk("t5_start_ign_words", words_loaded, 1);
      send_byte(8'hB1); send_byte(8'hB2);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ready", in_ready, 1);
      chk("t5_rst_hold", cpu_hold, 1);
      chk("t5_rst_we", mem_we, 0);
      chk("t5_rst_addr", mem_addr, 0);
      chk("t5_rst_wdata", mem_wdata, 0);
      chk("t5_rst_done", done, 0);
      chk("t5_rst_words", words_loaded, 0);
      @(negedge clk1);
      rst_n = 1'b1;
      chk("t5_pre_nwr", wq.size(), 1);
      wq.delete();
      send_byte(8'h00); send_byte(8'h01);
      send_word(32'hAABBCCDD);
      @(negedge clk1);
      chk("t5_done", done, 1);
      settle();
      chk("t5_nwr", wq.size(), 1);
      if (wq.size() == 1) begin
         chk("t5_a0", wq[0].a, 0); chk("t5_d0", wq[0].d, 32'hAABBCCDD);
      end

      // full-depth load
      pulse_start();
      wq.delete();
      send_byte(8'h04); send_byte(8'h00);
      chk("t6_no_err", err, 0);
      for (int i = 0; i < 1024; i++) send_word(32'h5000_0000 + 32'(i));
      @(negedge clk1);
      chk("t6_done", done, 1);
      chk("t6_words", words_loaded, 1024);
      settle();
      chk("t6_nwr", wq.size(), 1024);
      if (wq.size() == 1024) begin
         for (int i = 0; i < 1024; i++) begin
            chk("t6_addr", wq[i].a, 32'(i));
            chk("t6_data", wq[i].d, 32'h5000_0000 + 32'(i));
         end
         chk("t6_last_addr", wq[1023].a, 1023);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
